// File: rtl/fifo16_ram_ctrl.sv
// -----------------------------------------------------------------------------
// fifo16_ram_ctrl
//
// Controller for a 16-deep FIFO built from WIDTH parallel 16x1 single-port
// distributed RAM slices. There is one shared address, a synchronous write and
// an asynchronous read. The block keeps the read/write pointers and the fill
// count, and it arbitrates the single RAM address between writes and refills.
// Read data is registered into a show-ahead output stage. Total capacity is
// 17 words: 16 in the RAM and 1 in the output register.
//
// Ports:
//   CLK     clock; all registers and the slice write use the rising edge
//   CLR     asynchronous, active-high reset (RAM contents are not cleared)
//   WR_EN   push request from the producer
//   DIN     push data
//   WR_RDY  a push is accepted this cycle when WR_EN=1
//   RD_EN   pop request from the consumer (ignored while EMPTY)
//   DOUT    head-of-FIFO data, registered
//   EMPTY   DOUT is not valid
//   COUNT   total entries held, 0..17
//   RAM_A   shared address to all slices
//   RAM_WE  slice write enable
//   RAM_D   slice write data (always DIN)
//   RAM_O   slice asynchronous read data
// -----------------------------------------------------------------------------
module fifo16_ram_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  output logic             WR_RDY,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             EMPTY,
  output logic [4:0]       COUNT,
  output logic [3:0]       RAM_A,
  output logic             RAM_WE,
  output logic [WIDTH-1:0] RAM_D,
  input  logic [WIDTH-1:0] RAM_O
);

  // The single RAM address allows one of these actions per cycle.
  typedef enum logic [1:0] {
    ACT_IDLE,
    ACT_BYPASS,
    ACT_WRITE,
    ACT_REFILL
  } action_e;

  logic [3:0]       wptr, wptr_nxt;
  logic [3:0]       rptr, rptr_nxt;
  logic [4:0]       mcount, mcount_nxt;
  logic             dvalid, dvalid_nxt;
  logic [WIDTH-1:0] dreg, dreg_nxt;

  logic    refill_req;
  logic    push;
  logic    pop;
  logic    mem_empty;
  action_e action;

  assign mem_empty = (mcount == 5'd0);

  // Output flags come from registers only, so WR_RDY and EMPTY never depend
  // combinationally on WR_EN or RD_EN.
  assign refill_req = !mem_empty && !dvalid;
  assign WR_RDY     = !CLR && (mcount != 5'd16) && !refill_req;
  assign EMPTY      = !dvalid;
  assign DOUT       = dreg;
  assign COUNT      = mcount + {4'd0, dvalid};
  assign RAM_D      = DIN;

  assign push = WR_EN && WR_RDY;
  assign pop  = RD_EN && dvalid;

  // Action select, in priority order. A push always wins the RAM address; a
  // pending refill is served on the following cycle because refill_req then
  // drops WR_RDY.
  always_comb begin
    if (push && mem_empty && (!dvalid || pop)) begin
      action = ACT_BYPASS;
    end else if (push) begin
      action = ACT_WRITE;
    end else if (!mem_empty && (!dvalid || pop)) begin
      action = ACT_REFILL;
    end else begin
      action = ACT_IDLE;
    end
  end

  // NOTE: every signal written here gets a default first; a missing branch
  // would otherwise hold its old value and infer a latch.
  always_comb begin
    wptr_nxt   = wptr;
    rptr_nxt   = rptr;
    mcount_nxt = mcount;
    dvalid_nxt = dvalid;
    dreg_nxt   = dreg;
    RAM_A      = rptr;
    RAM_WE     = 1'b0;

    unique case (action)
      ACT_BYPASS: begin
        // Empty RAM: the pushed word goes straight into the output register.
        RAM_A      = wptr;
        dreg_nxt   = DIN;
        dvalid_nxt = 1'b1;
      end
      ACT_WRITE: begin
        RAM_A      = wptr;
        RAM_WE     = 1'b1;
        wptr_nxt   = wptr + 4'd1;
        mcount_nxt = mcount + 5'd1;
        // The address is busy with the write, so a popped head cannot be
        // replaced this cycle.
        if (pop) dvalid_nxt = 1'b0;
      end
      ACT_REFILL: begin
        dreg_nxt   = RAM_O;
        dvalid_nxt = 1'b1;
        rptr_nxt   = rptr + 4'd1;
        mcount_nxt = mcount - 5'd1;
      end
      default: begin
        if (pop) dvalid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: only the control state is reset; the RAM slices keep their
  // contents, which is harmless because the pointers and count restart.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wptr   <= 4'd0;
      rptr   <= 4'd0;
      mcount <= 5'd0;
      dvalid <= 1'b0;
      dreg   <= '0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      mcount <= mcount_nxt;
      dvalid <= dvalid_nxt;
      dreg   <= dreg_nxt;
    end
  end

endmodule
